// File: rtl/stereo_seq_ctrl.sv
// stereo_seq_ctrl: UART command sequencer for the stereo vision core.
// Decodes command bytes, moves image data between UART and SRAM banks and
// runs the window-load / compute / write-back disparity loop.
// Optional abort-on-0xFF support: define STEREO_SEQ_ABORT_EN.
//
// Handshake: a request (sram_req or tx_req) stays high until its 1-cycle ack.
// The transfer completes on the cycle where request and ack are both high.
// The request drops on the next cycle (gap_q), and at least one idle cycle
// always separates two requests. An ack with its request low is ignored.
module stereo_seq_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int IMG_PIXELS = 4096,
  parameter int BANKS      = 3,
  parameter int BANK_W     = 2,
  parameter int WIN_L_LEN  = 9,
  parameter int WIN_R_LEN  = 25
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [7:0]        cmd_in,
  input  logic              rx_drdy,
  output logic              tx_req,
  input  logic              tx_ack,
  output logic              sram_req,
  output logic              sram_we,
  input  logic              sram_ack,
  output logic [BANK_W-1:0] bank_sel,
  output logic [ADDR_W-1:0] addr_out,
  output logic              wr_data_sel,
  output logic              load_window,
  output logic              win_sel,
  output logic              disp_start,
  input  logic              disp_done,
  output logic              busy,
  output logic              done,
  output logic              cmd_err,
  output logic              rx_ovr
);
  localparam int                WIN_W      = $clog2(WIN_R_LEN + 1);
  localparam logic [ADDR_W-1:0] P_LAST     = ADDR_W'(IMG_PIXELS - 1);
  localparam logic [WIN_W-1:0]  L_LAST     = WIN_W'(WIN_L_LEN - 1);
  localparam logic [WIN_W-1:0]  R_LAST     = WIN_W'(WIN_R_LEN - 1);
  localparam logic [3:0]        BANKS_N    = 4'(BANKS);
  localparam logic [BANK_W-1:0] LEFT_BANK  = '0;
  localparam logic [BANK_W-1:0] RIGHT_BANK = BANK_W'(1);
  localparam logic [BANK_W-1:0] DISP_BANK  = BANK_W'(BANKS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_RX, S_WR_MEM, S_RD_MEM, S_RD_TX,
    S_LD_L, S_LD_R, S_START, S_WAIT, S_DWR, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] p_q, p_d;          // output pixel index
  logic [ADDR_W-1:0] waddr_q, waddr_d;  // (p + i) mod IMG_PIXELS
  logic [WIN_W-1:0]  i_q, i_d;          // window pixel index
  logic [BANK_W-1:0] bank_q, bank_d;
  logic              cmd_err_q, cmd_err_d;
  logic              rx_ovr_q, rx_ovr_d;
  logic              gap_q;
  logic              sram_fire, tx_fire, cmd_legal, abort_hit;

  assign sram_fire = sram_req && sram_ack;
  assign tx_fire   = tx_req && tx_ack;
  assign cmd_legal = (((cmd_in[7:4] == 4'h1) || (cmd_in[7:4] == 4'h2)) &&
                      (cmd_in[3:0] < BANKS_N)) || (cmd_in == 8'h30);
  assign cmd_err   = cmd_err_q;
  assign rx_ovr    = rx_ovr_q;

`ifdef STEREO_SEQ_ABORT_EN
  logic abort_q, abort_d;
  assign abort_hit = rx_drdy && (cmd_in == 8'hFF) && busy;
`else
  assign abort_hit = 1'b0;
`endif

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    return (a == P_LAST) ? '0 : a + ADDR_W'(1);
  endfunction

  // State register and counters; synchronous active-low reset
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= S_IDLE;
      p_q       <= '0;
      waddr_q   <= '0;
      i_q       <= '0;
      bank_q    <= '0;
      cmd_err_q <= 1'b0;
      rx_ovr_q  <= 1'b0;
      gap_q     <= 1'b0;
`ifdef STEREO_SEQ_ABORT_EN
      abort_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      waddr_q   <= waddr_d;
      i_q       <= i_d;
      bank_q    <= bank_d;
      cmd_err_q <= cmd_err_d;
      rx_ovr_q  <= rx_ovr_d;
      gap_q     <= sram_fire || tx_fire;
`ifdef STEREO_SEQ_ABORT_EN
      abort_q   <= abort_d;
`endif
    end
  end

  // Next-state, counter and sticky-flag logic
  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    waddr_d   = waddr_q;
    i_d       = i_q;
    bank_d    = bank_q;
    cmd_err_d = cmd_err_q;
    rx_ovr_d  = rx_ovr_q;
`ifdef STEREO_SEQ_ABORT_EN
    abort_d   = abort_q || abort_hit;
`endif
    // Bytes arriving while not waiting for a command or data are overruns.
    if (rx_drdy && (state_q != S_IDLE) && (state_q != S_WR_RX) && !abort_hit)
      rx_ovr_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (rx_drdy) begin
          if (cmd_legal) begin
            cmd_err_d = 1'b0;
            rx_ovr_d  = 1'b0;
            p_d       = '0;
            waddr_d   = '0;
            i_d       = '0;
            bank_d    = cmd_in[BANK_W-1:0];
            if (cmd_in[7:4] == 4'h1)      state_d = S_WR_RX;
            else if (cmd_in[7:4] == 4'h2) state_d = S_RD_MEM;
            else                          state_d = S_LD_L;
          end
`ifdef STEREO_SEQ_ABORT_EN
          else if (cmd_in != 8'hFF) cmd_err_d = 1'b1;
`else
          else cmd_err_d = 1'b1;
`endif
        end
      end
      S_WR_RX:  if (rx_drdy && !abort_hit) state_d = S_WR_MEM;
      S_WR_MEM: begin
        if (sram_fire) begin
          if (p_q == P_LAST) state_d = S_FIN;
          else begin
            p_d     = p_q + ADDR_W'(1);
            state_d = S_WR_RX;
          end
        end
      end
      S_RD_MEM: if (sram_fire) state_d = S_RD_TX;
      S_RD_TX: begin
        if (tx_fire) begin
          if (p_q == P_LAST) state_d = S_FIN;
          else begin
            p_d     = p_q + ADDR_W'(1);
            state_d = S_RD_MEM;
          end
        end
      end
      S_LD_L: begin
        if (sram_fire) begin
          if (i_q == L_LAST) begin
            i_d     = '0;
            waddr_d = p_q;
            state_d = S_LD_R;
          end else begin
            i_d     = i_q + WIN_W'(1);
            waddr_d = wrap_inc(waddr_q);
          end
        end
      end
      S_LD_R: begin
        if (sram_fire) begin
          if (i_q == R_LAST) begin
            i_d     = '0;
            state_d = S_START;
          end else begin
            i_d     = i_q + WIN_W'(1);
            waddr_d = wrap_inc(waddr_q);
          end
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT:  if (disp_done) state_d = S_DWR;
      S_DWR: begin
        if (sram_fire) begin
          if (p_q == P_LAST) state_d = S_FIN;
          else begin
            p_d     = p_q + ADDR_W'(1);
            waddr_d = p_q + ADDR_W'(1);
            state_d = S_LD_L;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
`ifdef STEREO_SEQ_ABORT_EN
        abort_d = 1'b0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
`ifdef STEREO_SEQ_ABORT_EN
    // Abort: let an already-raised request see its ack, then finish.
    if (abort_q && (state_q != S_IDLE) && (state_q != S_FIN)) begin
      if ((sram_req && !sram_ack) || (tx_req && !tx_ack)) state_d = state_q;
      else                                                  state_d = S_FIN;
    end
`endif
  end

  // Moore outputs decoded from the state; requests held low during the gap
  always_comb begin
    tx_req      = 1'b0;
    sram_req    = 1'b0;
    sram_we     = 1'b0;
    bank_sel    = '0;
    addr_out    = '0;
    wr_data_sel = 1'b0;
    win_sel     = 1'b0;
    disp_start  = 1'b0;
    busy        = (state_q != S_IDLE) && (state_q != S_FIN);
    done        = (state_q == S_FIN);
    case (state_q)
      S_WR_MEM: begin
        sram_req = !gap_q;
        sram_we  = 1'b1;
        bank_sel = bank_q;
        addr_out = p_q;
      end
      S_RD_MEM: begin
        sram_req = !gap_q;
        bank_sel = bank_q;
        addr_out = p_q;
      end
      S_RD_TX: begin
        tx_req   = !gap_q;
        bank_sel = bank_q;
        addr_out = p_q;
      end
      S_LD_L: begin
        sram_req = !gap_q;
        bank_sel = LEFT_BANK;
        addr_out = waddr_q;
      end
      S_LD_R: begin
        sram_req = !gap_q;
        bank_sel = RIGHT_BANK;
        addr_out = waddr_q;
        win_sel  = 1'b1;
      end
      S_START: disp_start = 1'b1;
      S_DWR: begin
        sram_req    = !gap_q;
        sram_we     = 1'b1;
        bank_sel    = DISP_BANK;
        addr_out    = p_q;
        wr_data_sel = 1'b1;
      end
      default: ;
    endcase
  end

  // Window load strobe coincides with each accepted read in the load states
  always_comb begin
    load_window = sram_fire && ((state_q == S_LD_L) || (state_q == S_LD_R));
  end
endmodule

// File: tb/tb_stereo_seq_ctrl.sv
// tb_stereo_seq_ctrl: directed bench for stereo_seq_ctrl with small image
// (16 pixels, 3/5 window). Models SRAM, UART tx and the disparity engine,
// logs every completed SRAM transfer and compares against hand-built lists.
module tb_stereo_seq_ctrl;
  localparam int ADDR_W = 8;
  localparam int IMG    = 16;
  localparam int BANKS  = 3;
  localparam int BANK_W = 2;
  localparam int WL     = 3;
  localparam int WR     = 5;
`ifdef STEREO_SEQ_ABORT_EN
  localparam int EXP_FF_IDLE_ERR = 0;
`else
  localparam int EXP_FF_IDLE_ERR = 1;
`endif

  logic              clk, rst_n;
  logic [7:0]        cmd_in;
  logic              rx_drdy, tx_req, tx_ack, sram_req, sram_we, sram_ack;
  logic [BANK_W-1:0] bank_sel;
  logic [ADDR_W-1:0] addr_out;
  logic              wr_data_sel, load_window, win_sel, disp_start, disp_done;
  logic              busy, done, cmd_err, rx_ovr;

  // Record of one SRAM transfer: {we, wr_data_sel, win_sel, bank, addr}
  logic [12:0] obs_q[$];
  logic [12:0] exp_q[$];
  logic [7:0]  tx_obs_q[$];
  logic [7:0]  tx_exp_q[$];
  logic [7:0]  rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int n_lw = 0, n_ds = 0, n_done = 0, n_viol = 0, n_req_idle = 0;

  stereo_seq_ctrl #(
    .ADDR_W(ADDR_W), .IMG_PIXELS(IMG), .BANKS(BANKS), .BANK_W(BANK_W),
    .WIN_L_LEN(WL), .WIN_R_LEN(WR)
  ) dut (
    .clk_in(clk), .rst_in(rst_n), .cmd_in(cmd_in), .rx_drdy(rx_drdy),
    .tx_req(tx_req), .tx_ack(tx_ack), .sram_req(sram_req), .sram_we(sram_we),
    .sram_ack(sram_ack), .bank_sel(bank_sel), .addr_out(addr_out),
    .wr_data_sel(wr_data_sel), .load_window(load_window), .win_sel(win_sel),
    .disp_start(disp_start), .disp_done(disp_done), .busy(busy), .done(done),
    .cmd_err(cmd_err), .rx_ovr(rx_ovr)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    cmd_in  = b;
    rx_drdy = 1'b1;
    @(negedge clk);
    rx_drdy = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    bit got = 1'b0;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (sram_req && sram_ack) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      #4;
    end
    check(tag, 32'(got), 1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #4;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check(tag, 32'(got), 1);
  endtask

  task automatic compare_log(input string tag, input int base);
    check({tag, "_count"}, 32'(obs_q.size() - base), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (base + i < obs_q.size())
        check($sformatf("%s_xfer%0d", tag, i), 32'(obs_q[base + i]), 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  function automatic logic [12:0] rec(input logic we, input logic sel, input logic win,
                                      input logic [1:0] bank, input int addr);
    return {we, sel, win, bank, 8'(addr)};
  endfunction

  // SRAM, UART tx and disparity engine models
  initial begin : responder
    int scnt, tcnt, dcnt;
    scnt = 0; tcnt = 0; dcnt = 0;
    sram_ack = 1'b0; tx_ack = 1'b0; disp_done = 1'b0; rdata = 8'h00;
    forever begin
      @(negedge clk);
      sram_ack  = 1'b0;
      tx_ack    = 1'b0;
      disp_done = 1'b0;
      if (sram_req === 1'b1) begin
        scnt++;
        if (scnt >= 2) begin
          sram_ack = 1'b1;
          scnt     = 0;
          obs_q.push_back({sram_we, wr_data_sel, win_sel, bank_sel, addr_out});
          if (!sram_we) rdata = addr_out ^ 8'hA5;
        end
      end else scnt = 0;
      if (tx_req === 1'b1) begin
        tcnt++;
        if (tcnt >= 2) begin
          tx_ack = 1'b1;
          tcnt   = 0;
          tx_obs_q.push_back(rdata);
        end
      end else tcnt = 0;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) disp_done = 1'b1;
      end
      if (disp_start === 1'b1) dcnt = 3;
    end
  end

  // Per-cycle monitor: pulse counters and request-spacing invariants
  initial begin : monitor
    logic prev_fire;
    prev_fire = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (prev_fire && (sram_req || tx_req)) n_viol++;
        if (done && busy) n_viol++;
        if (sram_req && !busy) n_req_idle++;
        n_lw   += int'(load_window);
        n_ds   += int'(disp_start);
        n_done += int'(done);
      end
      prev_fire = (sram_req && sram_ack) || (tx_req && tx_ack);
    end
  end

  // Directed stimulus
  initial begin
    int base, d0, lw0, ds0, tb0, ri0, n0;
    bit seen;
    cmd_in = 8'h00; rx_drdy = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_outputs", 32'({tx_req, sram_req, sram_we, bank_sel, addr_out, wr_data_sel,
          load_window, win_sel, disp_start, busy, done, cmd_err, rx_ovr}), 0);

    // Write 16 bytes to bank 1
    base = obs_q.size(); d0 = n_done;
    send_byte(8'h11);
    #1 check("wr_busy_after_accept", 32'(busy), 1);
    for (int k = 0; k < IMG; k++) begin
      send_byte(8'(k));
      wait_ack("wr_ack_seen");
      exp_q.push_back(rec(1'b1, 1'b0, 1'b0, 2'd1, k));
    end
    wait_done("wr_done_seen", 20);
    @(negedge clk); #4;
    check("wr_busy_after_done", 32'(busy), 0);
    check("wr_done_pulses", 32'(n_done - d0), 1);
    compare_log("wr", base);

    // Read bank 0 and send over UART
    base = obs_q.size(); d0 = n_done; tb0 = tx_obs_q.size();
    for (int k = 0; k < IMG; k++) begin
      exp_q.push_back(rec(1'b0, 1'b0, 1'b0, 2'd0, k));
      tx_exp_q.push_back(8'(k) ^ 8'hA5);
    end
    send_byte(8'h20);
    wait_done("rd_done_seen", 400);
    @(negedge clk); #4;
    check("rd_done_pulses", 32'(n_done - d0), 1);
    compare_log("rd", base);
    check("rd_tx_count", 32'(tx_obs_q.size() - tb0), 32'(IMG));
    foreach (tx_exp_q[i])
      if (tb0 + i < tx_obs_q.size())
        check($sformatf("rd_tx_byte%0d", i), 32'(tx_obs_q[tb0 + i]), 32'(tx_exp_q[i]));

    // Disparity loop
    base = obs_q.size(); d0 = n_done; lw0 = n_lw; ds0 = n_ds;
    for (int p = 0; p < IMG; p++) begin
      for (int i = 0; i < WL; i++) exp_q.push_back(rec(1'b0, 1'b0, 1'b0, 2'd0, (p + i) % IMG));
      for (int i = 0; i < WR; i++) exp_q.push_back(rec(1'b0, 1'b0, 1'b1, 2'd1, (p + i) % IMG));
      exp_q.push_back(rec(1'b1, 1'b1, 1'b0, 2'd2, p));
    end
    send_byte(8'h30);
    wait_done("disp_done_seen", 3000);
    @(negedge clk); #4;
    check("disp_load_window_pulses", 32'(n_lw - lw0), 32'(IMG * (WL + WR)));
    check("disp_start_pulses", 32'(n_ds - ds0), 32'(IMG));
    check("disp_done_pulses", 32'(n_done - d0), 1);
    compare_log("disp", base);

    // Illegal commands, then a legal one clears the error
    send_byte(8'h17);
    #1 check("err_bank7_cmd_err", 32'(cmd_err), 1);
    check("err_bank7_busy", 32'(busy), 0);
    send_byte(8'h55);
    #1 check("err_0x55_cmd_err", 32'(cmd_err), 1);
    check("err_0x55_busy", 32'(busy), 0);
    send_byte(8'h10);
    #1 check("err_cleared", 32'(cmd_err), 0);
    check("err_legal_busy", 32'(busy), 1);

    // Byte during WR_MEM is an overrun and is dropped
    base = obs_q.size();
    send_byte(8'hA0);
    cmd_in  = 8'hEE;
    rx_drdy = 1'b1;
    @(negedge clk);
    rx_drdy = 1'b0;
    #1 check("ovr_flag_set", 32'(rx_ovr), 1);
    wait_ack("ovr_ack0_seen");
    send_byte(8'hA1);
    wait_ack("ovr_ack1_seen");
    exp_q.push_back(rec(1'b1, 1'b0, 1'b0, 2'd0, 0));
    exp_q.push_back(rec(1'b1, 1'b0, 1'b0, 2'd0, 1));
    repeat (2) @(negedge clk);
    compare_log("ovr", base);

    // Reset for one cycle in the middle of a write, with a byte on rx
    send_byte(8'hA2);
    #1 check("pre_reset_sram_req", 32'(sram_req), 1);
    rst_n   = 1'b0;
    cmd_in  = 8'h21;
    rx_drdy = 1'b1;
    @(negedge clk);
    rst_n   = 1'b1;
    rx_drdy = 1'b0;
    #1 check("mid_reset_outputs", 32'({tx_req, sram_req, sram_we, bank_sel, addr_out,
          wr_data_sel, load_window, win_sel, disp_start, busy, done, cmd_err, rx_ovr}), 0);
    repeat (2) @(negedge clk);
    #1 check("post_reset_idle", 32'(busy), 0);

`ifdef STEREO_SEQ_ABORT_EN
    // Abort during the first right-window read
    base = obs_q.size(); d0 = n_done; ri0 = n_req_idle;
    for (int i = 0; i < WL; i++) exp_q.push_back(rec(1'b0, 1'b0, 1'b0, 2'd0, i));
    exp_q.push_back(rec(1'b0, 1'b0, 1'b1, 2'd1, 0));
    send_byte(8'h30);
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #4;
      if (win_sel && sram_req && !sram_ack) begin
        seen = 1'b1;
        break;
      end
    end
    check("abort_ldr_reached", 32'(seen), 1);
    n0 = obs_q.size();
    cmd_in  = 8'hFF;
    rx_drdy = 1'b1;
    @(negedge clk);
    rx_drdy = 1'b0;
    wait_done("abort_done_seen", 20);
    repeat (10) @(negedge clk);
    #4;
    check("abort_inflight_completes", 32'(obs_q.size() - n0), 1);
    check("abort_done_pulses", 32'(n_done - d0), 1);
    check("abort_cmd_err", 32'(cmd_err), 0);
    check("abort_rx_ovr", 32'(rx_ovr), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_no_req_after", 32'(n_req_idle - ri0), 0);
    compare_log("abort", base);
`endif

    // 0xFF in IDLE
    send_byte(8'hFF);
    #1 check("ff_idle_cmd_err", 32'(cmd_err), 32'(EXP_FF_IDLE_ERR));
    check("ff_idle_busy", 32'(busy), 0);

    repeat (2) @(negedge clk);
    check("req_spacing_violations", 32'(n_viol), 0);
    check("req_while_idle", 32'(n_req_idle), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
